// File: rtl/smg_pkg.sv
// Shared types and frame layout for the seven-segment display sequencer.
// Holds the state encoding, byte positions of the IR frame and the complement check.
package smg_pkg;

   typedef enum logic [1:0] {
      ST_BLANK = 2'd0,
      ST_SHOW  = 2'd1,
      ST_ERR   = 2'd2
   } state_t;

   localparam int ADDR_LSB  = 24;
   localparam int NADDR_LSB = 16;
   localparam int CMD_LSB   = 8;
   localparam int NCMD_LSB  = 0;

   // A frame is good when each inverted byte is the exact complement of its partner.
   function automatic logic frame_ok(input logic [31:0] d);
      return (d[NADDR_LSB +: 8] == ~d[ADDR_LSB +: 8]) &&
             (d[NCMD_LSB +: 8]  == ~d[CMD_LSB +: 8]);
   endfunction

endpackage

// File: rtl/smg_tick_cnt.sv
// Loadable down-counter that parks at zero and flags the terminal count.
// A load wins over counting; counting only happens while enabled.
module smg_tick_cnt #(
   parameter int W = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_en,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/smg_disp_ctrl.sv
// Display sequencer: validates IR frames, holds good ones on the digits for a
// timeout and blinks an error indication for corrupt ones before blanking.
module smg_disp_ctrl
   import smg_pkg::*;
#(
   parameter int HOLD_CYC  = 250_000_000,
   parameter int ERR_CYC   = 100_000_000,
   parameter int BLINK_CYC = 12_500_000,
   parameter int CHECK_EN  = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_ir_data,
   input  logic        i_ir_data_vld,
   input  logic        i_ir_repeat,
   output logic [31:0] o_disp_data,
   output logic [7:0]  o_digit_en,
   output logic        o_disp_vld,
   output logic        o_err_flag,
   output logic [1:0]  o_state
);

   localparam int TMR_MAX = (HOLD_CYC > ERR_CYC) ? HOLD_CYC : ERR_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX);
   localparam int BLK_W   = $clog2(BLINK_CYC);

   if (HOLD_CYC < 2 || ERR_CYC < 2 || BLINK_CYC < 2) begin : g_param_chk
      $error("smg_disp_ctrl: HOLD_CYC, ERR_CYC and BLINK_CYC must all be >= 2");
   end

   state_t      r_state;
   logic [31:0] r_disp_data;
   logic [7:0]  r_digit_en;
   logic        r_disp_vld;
   logic        r_err_flag;
   logic        r_blink_ph;

   logic             w_ok;
   logic             w_bad_frame;
   logic             w_tmr_load;
   logic [TMR_W-1:0] w_tmr_val;
   logic             w_tmr_zero;
   logic             w_blk_load;
   logic             w_blk_zero;

   assign w_ok        = (CHECK_EN == 0) ? 1'b1 : frame_ok(i_ir_data);
   assign w_bad_frame = i_ir_data_vld && !w_ok;

   // Repeat codes only extend the hold while a frame is on show.
   assign w_tmr_load = i_ir_data_vld || ((r_state == ST_SHOW) && i_ir_repeat);
   assign w_tmr_val  = w_bad_frame ? TMR_W'(ERR_CYC - 1) : TMR_W'(HOLD_CYC - 1);
   assign w_blk_load = w_bad_frame || ((r_state == ST_ERR) && w_blk_zero);

   smg_tick_cnt #(.W(TMR_W)) u_hold_tmr (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .i_en       (1'b1),
      .o_zero     (w_tmr_zero)
   );

   smg_tick_cnt #(.W(BLK_W)) u_blink_tmr (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (w_blk_load),
      .i_load_val (BLK_W'(BLINK_CYC - 1)),
      .i_en       (r_state == ST_ERR),
      .o_zero     (w_blk_zero)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= ST_BLANK;
         r_disp_data <= 32'h0;
         r_digit_en  <= 8'h00;
         r_disp_vld  <= 1'b0;
         r_err_flag  <= 1'b0;
         r_blink_ph  <= 1'b0;
      end else if (i_ir_data_vld) begin
         r_digit_en <= 8'hFF;
         if (w_ok) begin
            r_state     <= ST_SHOW;
            r_disp_data <= i_ir_data;
            r_disp_vld  <= 1'b1;
            r_err_flag  <= 1'b0;
            r_blink_ph  <= 1'b0;
         end else begin
            r_state    <= ST_ERR;
            r_disp_vld <= 1'b0;
            r_err_flag <= 1'b1;
            r_blink_ph <= 1'b1;
         end
      end else begin
         r_disp_vld <= 1'b0;
         case (r_state)
            ST_SHOW: begin
               if (!i_ir_repeat && w_tmr_zero) begin
                  r_state    <= ST_BLANK;
                  r_digit_en <= 8'h00;
               end
            end
            ST_ERR: begin
               if (w_tmr_zero) begin
                  r_state    <= ST_BLANK;
                  r_digit_en <= 8'h00;
                  r_err_flag <= 1'b0;
                  r_blink_ph <= 1'b0;
               end else if (w_blk_zero) begin
                  r_blink_ph <= ~r_blink_ph;
                  r_digit_en <= {8{~r_blink_ph}};
               end
            end
            ST_BLANK: begin
               r_digit_en <= 8'h00;
            end
            default: begin
               r_state    <= ST_BLANK;
               r_digit_en <= 8'h00;
               r_err_flag <= 1'b0;
            end
         endcase
      end
   end

   assign o_disp_data = r_disp_data;
   assign o_digit_en  = r_digit_en;
   assign o_disp_vld  = r_disp_vld;
   assign o_err_flag  = r_err_flag;
   assign o_state     = r_state;

endmodule
